// File: rtl/bsg_manycore_accel_stream_fwd.sv
// ============================================================================
// Module      : bsg_manycore_accel_stream_fwd
// Description : Multi-channel strided remote-store streamer with shared FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_manycore_accel_stream_fwd #(
    parameter int num_chan_p        = 4,
    parameter int addr_width_p      = 14,
    parameter int data_width_p      = 32,
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 4,
    parameter int max_out_credits_p = 4,
    parameter int fifo_els_p        = 4
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   in_v_i,
    output logic                                   in_yumi_o,
    input  logic [addr_width_p-1:0]                in_addr_i,
    input  logic [data_width_p-1:0]                in_data_i,
    input  logic [data_width_p/8-1:0]              in_mask_i,
    output logic                                   out_v_o,
    input  logic                                   out_ready_i,
    output logic [addr_width_p-1:0]                out_addr_o,
    output logic [x_cord_width_p-1:0]              out_x_o,
    output logic [y_cord_width_p-1:0]              out_y_o,
    output logic [data_width_p-1:0]                out_data_o,
    output logic [data_width_p/8-1:0]              out_mask_o,
    input  logic [$clog2(max_out_credits_p+1)-1:0] out_credits_i,
    output logic                                   err_o,
    output logic                                   idle_o
);

    localparam int c_mask_w  = data_width_p / 8;
    localparam int c_dest_w  = x_cord_width_p + y_cord_width_p;
    localparam int c_cred_w  = $clog2(max_out_credits_p + 1);
    localparam int c_chan_w  = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;
    localparam int c_ptr_w   = $clog2(fifo_els_p);
    localparam int c_entry_w = addr_width_p + c_dest_w + data_width_p + c_mask_w;

    logic [addr_width_p-1:0] addr_q   [num_chan_p];
    logic [addr_width_p-1:0] stride_q [num_chan_p];
    logic [c_dest_w-1:0]     dest_q   [num_chan_p];
    logic [c_entry_w-1:0]    mem_q    [fifo_els_p];

    logic [c_ptr_w:0]        wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w:0]        rd_ptr_q, rd_ptr_d;
    logic                    err_q, err_d;

    logic [c_chan_w-1:0]     w_chan_idx;
    logic                    w_chan_ok;
    logic [1:0]              w_reg;
    logic                    w_is_push;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_yumi;
    logic                    w_cfg_wr;
    logic                    w_push;
    logic                    w_out_v;
    logic                    w_pop;
    logic [addr_width_p-1:0] w_sel_addr;
    logic [c_dest_w-1:0]     w_sel_dest;
    logic [c_entry_w-1:0]    w_entry_d;
    logic                    w_unused_addr;

    // A single channel needs no select bits, so every address maps to it.
    generate
        if (num_chan_p == 1) begin : g_one_chan
            assign w_chan_idx = '0;
            assign w_chan_ok  = 1'b1;
        end else begin : g_multi_chan
            assign w_chan_idx = in_addr_i[2 +: c_chan_w];
            assign w_chan_ok  = (int'(w_chan_idx) < num_chan_p);
        end
    endgenerate

    assign w_unused_addr = ^in_addr_i;
    assign w_reg         = in_addr_i[1:0];
    assign w_is_push     = (w_reg == 2'd3);

    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[c_ptr_w] != rd_ptr_q[c_ptr_w]) &&
                     (wr_ptr_q[c_ptr_w-1:0] == rd_ptr_q[c_ptr_w-1:0]);

    // Only a valid-channel push can stall; config and bad-channel writes always drain.
    assign w_yumi   = reset_n_i & in_v_i & (~w_is_push | ~w_chan_ok | ~w_full);
    assign w_cfg_wr = w_yumi & w_chan_ok & ~w_is_push;
    assign w_push   = w_yumi & w_chan_ok & w_is_push;

    assign w_out_v  = ~w_empty & (out_credits_i != '0);
    assign w_pop    = w_out_v & out_ready_i;

    always_comb begin
        w_sel_addr = '0;
        w_sel_dest = '0;
        for (int i = 0; i < num_chan_p; i++) begin
            if (w_chan_idx == c_chan_w'(i)) begin
                w_sel_addr = addr_q[i];
                w_sel_dest = dest_q[i];
            end
        end
    end

    assign w_entry_d = {w_sel_addr, w_sel_dest, in_data_i, in_mask_i};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_chan_p; i++) begin
                addr_q[i]   <= '0;
                stride_q[i] <= '0;
                dest_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < num_chan_p; i++) begin
                if (w_chan_idx == c_chan_w'(i)) begin
                    if (w_cfg_wr && (w_reg == 2'd0)) addr_q[i]   <= in_data_i[addr_width_p-1:0];
                    if (w_cfg_wr && (w_reg == 2'd1)) dest_q[i]   <= in_data_i[c_dest_w-1:0];
                    if (w_cfg_wr && (w_reg == 2'd2)) stride_q[i] <= in_data_i[addr_width_p-1:0];
                    if (w_push)                      addr_q[i]   <= addr_q[i] + stride_q[i];
                end
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + (w_push ? {{c_ptr_w{1'b0}}, 1'b1} : '0);
        rd_ptr_d = rd_ptr_q + (w_pop  ? {{c_ptr_w{1'b0}}, 1'b1} : '0);
        err_d    = err_q | (w_yumi & ~w_chan_ok);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

    // Payload storage carries no reset; the pointers alone define occupancy.
    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wr_ptr_q[c_ptr_w-1:0]] <= w_entry_d;
    end

    assign {out_addr_o, out_y_o, out_x_o, out_data_o, out_mask_o} = mem_q[rd_ptr_q[c_ptr_w-1:0]];

    assign in_yumi_o = w_yumi;
    assign out_v_o   = w_out_v;
    assign err_o     = err_q;
    assign idle_o    = w_empty & (out_credits_i == c_cred_w'(max_out_credits_p));

endmodule

`default_nettype wire

// File: tb/tb_bsg_manycore_accel_stream_fwd.sv
// ============================================================================
// Module      : tb_bsg_manycore_accel_stream_fwd
// Description : Directed bench with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bsg_manycore_accel_stream_fwd;

    localparam int NCH = 3;
    localparam int AW  = 14;
    localparam int DW  = 32;
    localparam int MW  = 4;
    localparam int CRW = 3;
    localparam int FE  = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_v;
    logic          in_yumi;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic [MW-1:0] in_mask;
    logic          out_v;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [3:0]    out_x;
    logic [3:0]    out_y;
    logic [DW-1:0] out_data;
    logic [MW-1:0] out_mask;
    logic [CRW-1:0] credits;
    logic          err;
    logic          idle;

    bsg_manycore_accel_stream_fwd #(
        .num_chan_p(NCH), .addr_width_p(AW), .data_width_p(DW),
        .x_cord_width_p(4), .y_cord_width_p(4),
        .max_out_credits_p(4), .fifo_els_p(FE)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .in_v_i(in_v), .in_yumi_o(in_yumi), .in_addr_i(in_addr),
        .in_data_i(in_data), .in_mask_i(in_mask),
        .out_v_o(out_v), .out_ready_i(out_ready), .out_addr_o(out_addr),
        .out_x_o(out_x), .out_y_o(out_y), .out_data_o(out_data),
        .out_mask_o(out_mask), .out_credits_i(credits),
        .err_o(err), .idle_o(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    x;
        logic [3:0]    y;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
    } ent_t;

    ent_t          q[$];
    ent_t          log_q[$];
    logic [AW-1:0] m_addr[NCH];
    logic [AW-1:0] m_stride[NCH];
    logic [7:0]    m_dest[NCH];
    logic          m_err;
    bit            m_full;
    bit            m_pop;
    int            m_ch;
    ent_t          m_e;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a store queue plus per-channel address/stride/dest state.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            for (int i = 0; i < NCH; i++) begin
                m_addr[i] = '0; m_stride[i] = '0; m_dest[i] = '0;
            end
            m_err = 1'b0;
        end else begin
            m_full = (q.size() == FE);
            m_pop  = (q.size() != 0) && (credits != 0) && out_ready;
            if (m_pop) begin
                log_q.push_back(q[0]);
                void'(q.pop_front());
            end
            if (in_v) begin
                m_ch = int'(in_addr[3:2]);
                if (m_ch >= NCH) m_err = 1'b1;
                else begin
                    case (in_addr[1:0])
                        2'd0: m_addr[m_ch]   = in_data[AW-1:0];
                        2'd1: m_dest[m_ch]   = in_data[7:0];
                        2'd2: m_stride[m_ch] = in_data[AW-1:0];
                        default: if (!m_full) begin
                            m_e.addr = m_addr[m_ch];
                            m_e.y    = m_dest[m_ch][7:4];
                            m_e.x    = m_dest[m_ch][3:0];
                            m_e.data = in_data;
                            m_e.mask = in_mask;
                            q.push_back(m_e);
                            m_addr[m_ch] = m_addr[m_ch] + m_stride[m_ch];
                        end
                    endcase
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit exp_v, exp_yumi, exp_idle;
        exp_v    = reset_n && (q.size() != 0) && (credits != 0);
        exp_yumi = reset_n && in_v &&
                   ((in_addr[1:0] != 2'd3) || (int'(in_addr[3:2]) >= NCH) || (q.size() < FE));
        exp_idle = (q.size() == 0) && (credits == 3'd4);
        chk("out_v", 64'(out_v), 64'(exp_v));
        chk("in_yumi", 64'(in_yumi), 64'(exp_yumi));
        chk("err", 64'(err), 64'(m_err));
        chk("idle", 64'(idle), 64'(exp_idle));
        if (exp_v) begin
            chk("head_addr", 64'(out_addr), 64'(q[0].addr));
            chk("head_xy", 64'({out_y, out_x}), 64'({q[0].y, q[0].x}));
            chk("head_data", 64'(out_data), 64'(q[0].data));
            chk("head_mask", 64'(out_mask), 64'(q[0].mask));
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input int ch, input int r, input logic [DW-1:0] d, input logic [MW-1:0] m);
        int n = 0;
        in_v = 1'b1; in_addr = AW'(ch * 4 + r); in_data = d; in_mask = m;
        do begin @(negedge clk); n++; end while (!in_yumi && n < 50);
        chk("write_accepted", 64'(in_yumi), 64'd1);
        @(posedge clk); #1;
        in_v = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        chk("drain_done", 64'(q.size()), 64'd0);
    endtask

    task automatic chk_log(input string name, input int idx, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        if (idx < log_q.size()) begin
            chk({name, "_addr"}, 64'(log_q[idx].addr), 64'(a));
            chk({name, "_data"}, 64'(log_q[idx].data), 64'(d));
        end else begin
            chk({name, "_present"}, 64'(log_q.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int b;
        reset_n = 1'b0; in_v = 1'b1; in_addr = 14'h3; in_data = '0; in_mask = '0;
        out_ready = 1'b0; credits = 3'd4;
        #3;
        chk("rst_out_v", 64'(out_v), 64'd0);
        chk("rst_yumi", 64'(in_yumi), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        in_v = 1'b0;
        cycles(2);
        reset_n = 1'b1;
        cycles(1);

        // ch1 stream of three stores to (y2,x3)
        out_ready = 1'b1;
        b = log_q.size();
        wr(1, 0, 32'h100, 4'h0); wr(1, 1, 32'h23, 4'h0); wr(1, 2, 32'd4, 4'h0);
        wr(1, 3, 32'hA, 4'hF); wr(1, 3, 32'hB, 4'hF); wr(1, 3, 32'hC, 4'hF);
        drain();
        chk_log("t1_s0", b, 14'h100, 32'hA);
        chk_log("t1_s1", b + 1, 14'h104, 32'hB);
        chk_log("t1_s2", b + 2, 14'h108, 32'hC);
        if (log_q.size() > b) begin
            chk("t1_xy", 64'({log_q[b].y, log_q[b].x}), 64'h23);
            chk("t1_mask", 64'(log_q[b].mask), 64'hF);
        end

        // FIFO full: fifth push is held until the cycle after the first pop
        out_ready = 1'b0;
        b = log_q.size();
        wr(0, 0, 32'h200, 4'h0); wr(0, 2, 32'd1, 4'h0);
        for (int k = 0; k < 4; k++) wr(0, 3, 32'h10 + k, 4'hF);
        in_v = 1'b1; in_addr = 14'h3; in_data = 32'h14; in_mask = 4'hF;
        @(negedge clk); chk("t2_held_a", 64'(in_yumi), 64'd0);
        @(negedge clk); chk("t2_held_b", 64'(in_yumi), 64'd0);
        @(posedge clk); #1; out_ready = 1'b1;
        @(negedge clk); chk("t2_pop_cycle", 64'(in_yumi), 64'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("t2_after_pop", 64'(in_yumi), 64'd1);
        @(posedge clk); #1; in_v = 1'b0;
        drain();
        for (int k = 0; k < 5; k++) chk_log("t2_s", b + k, 14'h200 + 14'(k), 32'h10 + k);

        // credit starvation holds the head
        out_ready = 1'b0;
        b = log_q.size();
        wr(0, 3, 32'h77, 4'hF); wr(0, 3, 32'h78, 4'hF);
        credits = 3'd0; out_ready = 1'b1;
        cycles(2);
        @(negedge clk);
        chk("t3_v_nocred", 64'(out_v), 64'd0);
        chk("t3_head_addr", 64'(out_addr), 64'h205);
        chk("t3_head_data", 64'(out_data), 64'h77);
        chk("t3_idle", 64'(idle), 64'd0);
        chk("t3_no_xfer", 64'(log_q.size() - b), 64'd0);
        @(posedge clk); #1; credits = 3'd1;
        cycles(1); chk("t3_one_xfer", 64'(log_q.size() - b), 64'd1);
        cycles(1); chk("t3_two_xfer", 64'(log_q.size() - b), 64'd2);
        chk_log("t3_s1", b + 1, 14'h206, 32'h78);
        credits = 3'd4;

        // address wrap on ch2
        b = log_q.size();
        wr(2, 0, 32'h3FFE, 4'h0); wr(2, 2, 32'd3, 4'h0); wr(2, 1, 32'h15, 4'h0);
        wr(2, 3, 32'hD1, 4'hF); wr(2, 3, 32'hD2, 4'h3);
        drain();
        chk_log("t4_s0", b, 14'h3FFE, 32'hD1);
        chk_log("t4_s1", b + 1, 14'h0001, 32'hD2);

        // nonexistent channel 3
        b = log_q.size();
        wr(3, 0, 32'h55, 4'h0);
        @(negedge clk); chk("t5_err_set", 64'(err), 64'd1);
        @(posedge clk); #1;
        wr(3, 3, 32'h99, 4'hF);
        wr(2, 3, 32'hD3, 4'hF);
        drain();
        chk("t5_only_one", 64'(log_q.size() - b), 64'd1);
        chk_log("t5_s0", b, 14'h0004, 32'hD3);
        chk("t5_err_sticky", 64'(err), 64'd1);

        // interleaved channels, then reset mid-stream
        b = log_q.size();
        wr(0, 0, 32'h10, 4'h0); wr(0, 2, 32'd2, 4'h0);
        wr(1, 0, 32'h20, 4'h0); wr(1, 2, 32'd5, 4'h0);
        wr(0, 3, 32'hE0, 4'hF); wr(1, 3, 32'hE1, 4'hF);
        wr(0, 3, 32'hE2, 4'hF); wr(1, 3, 32'hE3, 4'hF);
        drain();
        chk_log("t6_s0", b, 14'h10, 32'hE0);
        chk_log("t6_s1", b + 1, 14'h20, 32'hE1);
        chk_log("t6_s2", b + 2, 14'h12, 32'hE2);
        chk_log("t6_s3", b + 3, 14'h25, 32'hE3);
        out_ready = 1'b0;
        wr(0, 3, 32'hF0, 4'hF); wr(1, 3, 32'hF1, 4'hF); wr(0, 3, 32'hF2, 4'hF);
        @(negedge clk); chk("t6_queued_v", 64'(out_v), 64'd1);
        @(posedge clk); #2;
        in_v = 1'b1; in_addr = 14'h7; in_data = 32'hF3; in_mask = 4'hF;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_v", 64'(out_v), 64'd0);
        chk("t6_rst_yumi", 64'(in_yumi), 64'd0);
        chk("t6_rst_err", 64'(err), 64'd0);
        chk("t6_rst_idle", 64'(idle), 64'd1);
        in_v = 1'b0;
        @(posedge clk); #1; reset_n = 1'b1;
        cycles(2);
        chk("t6_empty_after", 64'(out_v), 64'd0);
        wr(0, 3, 32'hEE, 4'hF);
        @(negedge clk);
        chk("t6_post_v", 64'(out_v), 64'd1);
        chk("t6_post_addr", 64'(out_addr), 64'h0);
        chk("t6_post_xy", 64'({out_y, out_x}), 64'h0);
        @(posedge clk); #1; out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
